// File: rtl/exc_sched.sv
// Exception scheduler for the single-cycle MIPS core: fixed-priority arbitration,
// handler entry/return sequencing and double-fault trapping. Interrupts need EXC_SCHED_IRQ_EN.
module exc_sched #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter int          NIRQ         = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid,
    input  logic [31:0]     pc,
    input  logic            dz,
    input  logic            ov,
    input  logic            sys,
    input  logic            brk,
    input  logic [NIRQ-1:0] irq,
    input  logic [NIRQ-1:0] irq_mask,
    input  logic            eret,
    input  logic [31:0]     epc_in,
    output logic            cp0_int,
    output logic [31:0]     cp0_cause,
    output logic [31:0]     cp0_pc,
    output logic            flush,
    output logic            redirect,
    output logic [31:0]     target,
    output logic            exl,
    output logic            halt,
    output logic [NIRQ-1:0] pend
);

    typedef enum logic [2:0] {
        IDLE,
        ENTER,
        HANDLER,
        RETURN,
        HALT
    } state_t;

    state_t          state_q, state_d;
    logic [NIRQ-1:0] pend_q, pend_d;
    logic [31:0]     cause_q, cause_d;
    logic [31:0]     epc_q, epc_d;

    logic            syncFlag;
    logic            excEvent;
    logic [4:0]      excCode;
    logic [31:0]     causeEvt;

`ifdef EXC_SCHED_IRQ_EN
    assign pend_d = irq & irq_mask;
`else
    // Interrupt lines are deliberately dropped in this build.
    logic unusedIrq;
    assign unusedIrq = ^{irq, irq_mask};
    assign pend_d    = '0;
`endif

    assign syncFlag = dz | ov | sys | brk;
    assign excEvent = valid & (syncFlag | (|pend_q));

    // Interrupts only reach the cause word through the IP bits, so ExcCode stays 0 for them.
    always_comb begin
        excCode = 5'd0;
        if (dz) begin
            excCode = 5'd15;
        end else if (ov) begin
            excCode = 5'd12;
        end else if (sys) begin
            excCode = 5'd8;
        end else if (brk) begin
            excCode = 5'd9;
        end
        causeEvt             = '0;
        causeEvt[6:2]        = excCode;
        causeEvt[10 +: NIRQ] = pend_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        cp0_int  = 1'b0;
        flush    = 1'b0;
        redirect = 1'b0;
        target   = '0;
        exl      = 1'b0;
        halt     = 1'b0;
        case (state_q)
            IDLE: begin
                if (excEvent) begin
                    state_d = ENTER;
                    cause_d = causeEvt;
                    epc_d   = pc;
                end
            end
            ENTER: begin
                cp0_int  = 1'b1;
                flush    = 1'b1;
                redirect = 1'b1;
                target   = HANDLER_ADDR;
                exl      = 1'b1;
                state_d  = HANDLER;
            end
            HANDLER: begin
                exl = 1'b1;
                // A fault inside the handler beats a simultaneous eret.
                if (valid && syncFlag) begin
                    state_d = HALT;
                end else if (valid && eret) begin
                    state_d = RETURN;
                end
            end
            RETURN: begin
                flush    = 1'b1;
                redirect = 1'b1;
                target   = epc_in;
                exl      = 1'b1;
                state_d  = IDLE;
            end
            HALT: begin
                halt  = 1'b1;
                exl   = 1'b1;
                flush = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cp0_cause = cause_q;
    assign cp0_pc    = epc_q;
    assign pend      = pend_q;

endmodule

// File: tb/tb_exc_sched.sv
// Self-checking bench for exc_sched: table-driven synchronous exceptions, a cause/EPC
// scoreboard popped on every cp0_int, and hand-written handler/halt/interrupt sequences.
module tb_exc_sched;

    localparam logic [31:0] HADDR = 32'h0000_4180;
    localparam int          NIRQ  = 6;

    logic            clk;
    logic            rst_n;
    logic            valid;
    logic [31:0]     pc;
    logic            dz, ov, sys, brk;
    logic [NIRQ-1:0] irq, irqMask;
    logic            eret;
    logic [31:0]     epcIn;
    logic            cp0_int;
    logic [31:0]     cp0_cause, cp0_pc;
    logic            flush, redirect;
    logic [31:0]     target;
    logic            exl, halt;
    logic [NIRQ-1:0] pend;

    int passCount = 0;
    int checkCount = 0;

    typedef struct {
        logic [31:0] cause;
        logic [31:0] pc;
    } exp_t;
    exp_t sbq[$];
    exp_t sbExp;

    typedef struct {
        logic        vValid;
        logic        vDz, vOv, vSys, vBrk;
        logic [31:0] vPc;
        logic        expEvent;
        logic [31:0] expCause;
    } vec_t;
    vec_t vecs[8];

    exc_sched #(.HANDLER_ADDR(HADDR), .NIRQ(NIRQ)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .pc(pc),
        .dz(dz), .ov(ov), .sys(sys), .brk(brk),
        .irq(irq), .irq_mask(irqMask), .eret(eret), .epc_in(epcIn),
        .cp0_int(cp0_int), .cp0_cause(cp0_cause), .cp0_pc(cp0_pc),
        .flush(flush), .redirect(redirect), .target(target),
        .exl(exl), .halt(halt), .pend(pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic d, input logic o, input logic s,
                                 input logic b, input logic e, input logic [31:0] p,
                                 input logic [31:0] ep);
        valid = v; dz = d; ov = o; sys = s; brk = b; eret = e; pc = p; epcIn = ep;
    endtask

    // Called at the negedge inside the ENTER cycle; leaves the DUT in HANDLER.
    task automatic checkEntry(input string tag);
        checkOutput({tag, "_cp0_int"}, 32'(cp0_int), 32'd1);
        checkOutput({tag, "_flush"}, 32'(flush), 32'd1);
        checkOutput({tag, "_redirect"}, 32'(redirect), 32'd1);
        checkOutput({tag, "_target"}, target, HADDR);
        checkOutput({tag, "_exl"}, 32'(exl), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput({tag, "_hnd_cp0_int"}, 32'(cp0_int), 32'd0);
        checkOutput({tag, "_hnd_redirect"}, 32'(redirect), 32'd0);
        checkOutput({tag, "_hnd_exl"}, 32'(exl), 32'd1);
    endtask

    // Called at a negedge while in HANDLER; leaves the DUT in IDLE.
    task automatic doReturn(input string tag, input logic [31:0] ep);
        applyStimulus(1, 0, 0, 0, 0, 1, 32'h0, ep);
        @(negedge clk);
        checkOutput({tag, "_ret_redirect"}, 32'(redirect), 32'd1);
        checkOutput({tag, "_ret_flush"}, 32'(flush), 32'd1);
        checkOutput({tag, "_ret_target"}, target, ep);
        checkOutput({tag, "_ret_exl"}, 32'(exl), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput({tag, "_idle_exl"}, 32'(exl), 32'd0);
        checkOutput({tag, "_idle_redirect"}, 32'(redirect), 32'd0);
    endtask

    // Scoreboard: every handler entry must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && cp0_int === 1'b1) begin
            checkCount++;
            if (sbq.size() == 0) begin
                $display("[TB] FAIL sb_unexpected_entry: got cp0_int=1 with cause 0x%08h, expected no entry", cp0_cause);
            end else begin
                passCount++;
                sbExp = sbq.pop_front();
                checkOutput("sb_cause", cp0_cause, sbExp.cause);
                checkOutput("sb_pc", cp0_pc, sbExp.pc);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 1'b1, 32'h30};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 1'b1, 32'h3C};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0300, 1'b1, 32'h20};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0400, 1'b1, 32'h24};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEE0, 1'b1, 32'h30};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0004, 1'b1, 32'h20};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0500, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0600, 1'b0, 32'h0};

        rst_n = 1'b0;
        irq = '0;
        irqMask = '0;
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_ctrl", 32'({cp0_int, flush, redirect, exl, halt}), 32'd0);
        checkOutput("rst_target", target, 32'h0);
        checkOutput("rst_cause", cp0_cause, 32'h0);
        checkOutput("rst_pc", cp0_pc, 32'h0);
        checkOutput("rst_pend", 32'(pend), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].vValid, vecs[i].vDz, vecs[i].vOv, vecs[i].vSys, vecs[i].vBrk,
                          1'b0, vecs[i].vPc, 32'h0);
            if (vecs[i].expEvent) sbq.push_back('{vecs[i].expCause, vecs[i].vPc});
            @(negedge clk);
            if (vecs[i].expEvent) begin
                checkEntry($sformatf("vec%0d", i));
                checkOutput($sformatf("vec%0d_cause_held", i), cp0_cause, vecs[i].expCause);
                doReturn($sformatf("vec%0d", i), vecs[i].vPc + 32'd4);
            end else begin
                checkOutput($sformatf("vec%0d_no_exl", i), 32'(exl), 32'd0);
                checkOutput($sformatf("vec%0d_no_flush", i), 32'(flush), 32'd0);
                applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
                @(negedge clk);
            end
        end

        // eret outside a handler must be ignored.
        applyStimulus(1, 0, 0, 0, 0, 1, 32'h0000_0700, 32'h0000_0777);
        @(negedge clk);
        checkOutput("idle_eret_redirect", 32'(redirect), 32'd0);
        checkOutput("idle_eret_exl", 32'(exl), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);

        // Double fault: brk together with eret inside the handler.
        applyStimulus(1, 0, 0, 1, 0, 0, 32'h0000_0800, 32'h0);
        sbq.push_back('{32'h20, 32'h0000_0800});
        @(negedge clk);
        checkEntry("dfault");
        applyStimulus(0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("dfault_novalid_halt", 32'(halt), 32'd0);
        checkOutput("dfault_novalid_exl", 32'(exl), 32'd1);
        applyStimulus(1, 0, 0, 0, 1, 1, 32'h0, 32'h0000_0999);
        @(negedge clk);
        checkOutput("dfault_halt", 32'(halt), 32'd1);
        checkOutput("dfault_flush", 32'(flush), 32'd1);
        checkOutput("dfault_redirect", 32'(redirect), 32'd0);
        checkOutput("dfault_exl", 32'(exl), 32'd1);
        applyStimulus(1, 0, 0, 1, 0, 1, 32'h0, 32'h0000_0999);
        repeat (3) @(negedge clk);
        checkOutput("dfault_sticky_halt", 32'(halt), 32'd1);
        checkOutput("dfault_sticky_cp0_int", 32'(cp0_int), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_ctrl", 32'({cp0_int, flush, redirect, exl, halt}), 32'd0);
        checkOutput("midrst_cause", cp0_cause, 32'h0);
        checkOutput("midrst_pc", cp0_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef EXC_SCHED_IRQ_EN
        irq = 6'b000100;
        irqMask = 6'h3F;
        @(negedge clk);
        checkOutput("irq_pend", 32'(pend), 32'h04);
        checkOutput("irq_no_entry_without_valid", 32'(exl), 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0000_0A00, 32'h0);
        sbq.push_back('{32'h1000, 32'h0000_0A00});
        @(negedge clk);
        irq = 6'b000001;
        checkEntry("irq2");
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0000_0A04, 32'h0);
        @(negedge clk);
        checkOutput("irq_in_handler_exl", 32'(exl), 32'd1);
        checkOutput("irq_in_handler_no_int", 32'(cp0_int), 32'd0);
        doReturn("irq2", 32'h0000_0A04);
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0000_0A04, 32'h0);
        sbq.push_back('{32'h0400, 32'h0000_0A04});
        @(negedge clk);
        irq = '0;
        checkEntry("irq0");
        doReturn("irq0", 32'h0000_0A08);
        irq = 6'h3F;
        irqMask = 6'h00;
        @(negedge clk);
        checkOutput("irq_masked_pend", 32'(pend), 32'h0);
        irq = 6'b100000;
        irqMask = 6'h3F;
        @(negedge clk);
        checkOutput("irq5_pend", 32'(pend), 32'h20);
        applyStimulus(1, 0, 1, 0, 0, 0, 32'h0000_0B00, 32'h0);
        sbq.push_back('{32'h8030, 32'h0000_0B00});
        @(negedge clk);
        irq = '0;
        checkEntry("ov_over_irq");
        doReturn("ov_over_irq", 32'h0000_0B04);
`else
        irq = 6'h3F;
        irqMask = 6'h3F;
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0000_0C00, 32'h0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput($sformatf("noirq_pend_c%0d", c), 32'(pend), 32'h0);
            checkOutput($sformatf("noirq_cp0_int_c%0d", c), 32'(cp0_int), 32'd0);
        end
        irq = '0;
        irqMask = '0;
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
`endif

        checkOutput("sb_drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
